// File: rtl/video_csc_stream_arbiter.sv
// Two-source Avalon-ST packet arbiter feeding the colour-space converter.
// Whole packets are granted to one source at a time, with a round-robin
// tie-break. Non-sop beats arriving while idle are discarded and counted.
module video_csc_stream_arbiter #(
  parameter int DW = 23,
  parameter int EW = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW:0]   stream_in0_data,
  input  logic          stream_in0_startofpacket,
  input  logic          stream_in0_endofpacket,
  input  logic [EW:0]   stream_in0_empty,
  input  logic          stream_in0_valid,
  output logic          stream_in0_ready,
  input  logic [DW:0]   stream_in1_data,
  input  logic          stream_in1_startofpacket,
  input  logic          stream_in1_endofpacket,
  input  logic [EW:0]   stream_in1_empty,
  input  logic          stream_in1_valid,
  output logic          stream_in1_ready,
  input  logic [1:0]    port_enable,
  input  logic          stream_out_ready,
  output logic [DW:0]   stream_out_data,
  output logic          stream_out_startofpacket,
  output logic          stream_out_endofpacket,
  output logic [EW:0]   stream_out_empty,
  output logic          stream_out_valid,
  output logic          stream_out_channel,
  output logic [15:0]   pkt_count0,
  output logic [15:0]   pkt_count1,
  output logic [7:0]    drop_count
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t state, state_nxt;
  logic   prio, prio_nxt;
  logic   transfer;
  logic   cand0, cand1, have_win, win;
  logic   stray0, stray1;
  logic   rdy0, rdy1;
  logic   fwd, fwd_ch, fwd_eop;
  logic [1:0] drop_inc;

  // Add up to two discards to the drop counter, clamping at 255.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {7'd0, b};
    return (s > 9'd255) ? 8'd255 : s[7:0];
  endfunction

  // Arbitration, per-source ready and next-state decode.
  always_comb begin
    transfer  = ~stream_out_valid | stream_out_ready;
    cand0     = port_enable[0] & stream_in0_valid & stream_in0_startofpacket;
    cand1     = port_enable[1] & stream_in1_valid & stream_in1_startofpacket;
    have_win  = cand0 | cand1;
    win       = (cand0 & cand1) ? prio : cand1;
    stray0    = stream_in0_valid & ~stream_in0_startofpacket;
    stray1    = stream_in1_valid & ~stream_in1_startofpacket;
    rdy0      = 1'b0;
    rdy1      = 1'b0;
    fwd       = 1'b0;
    fwd_ch    = 1'b0;
    drop_inc  = 2'd0;
    state_nxt = state;
    prio_nxt  = prio;
    case (state)
      IDLE: begin
        // A stray beat can never be the winner, since winners carry sop.
        if (have_win && !win) rdy0 = transfer;
        if (have_win && win)  rdy1 = transfer;
        if (stray0) rdy0 = 1'b1;
        if (stray1) rdy1 = 1'b1;
        drop_inc = {1'b0, stray0} + {1'b0, stray1};
        if (have_win && transfer) begin
          fwd    = 1'b1;
          fwd_ch = win;
          if (win ? stream_in1_endofpacket : stream_in0_endofpacket)
            prio_nxt = ~win;
          else
            state_nxt = win ? GRANT1 : GRANT0;
        end
      end
      GRANT0: begin
        rdy0 = transfer;
        if (stream_in0_valid && transfer) begin
          fwd = 1'b1;
          if (stream_in0_endofpacket) begin
            state_nxt = IDLE;
            prio_nxt  = 1'b1;
          end
        end
      end
      GRANT1: begin
        rdy1   = transfer;
        fwd_ch = 1'b1;
        if (stream_in1_valid && transfer) begin
          fwd = 1'b1;
          if (stream_in1_endofpacket) begin
            state_nxt = IDLE;
            prio_nxt  = 1'b0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    fwd_eop = fwd_ch ? stream_in1_endofpacket : stream_in0_endofpacket;
  end

  // Readys are forced low while reset is held.
  assign stream_in0_ready = rdy0 & reset;
  assign stream_in1_ready = rdy1 & reset;

  // FSM state and round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      prio  <= 1'b0;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
    end
  end

  // Output beat register: loads on transfer, bubbles clear only valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stream_out_data          <= '0;
      stream_out_startofpacket <= 1'b0;
      stream_out_endofpacket   <= 1'b0;
      stream_out_empty         <= '0;
      stream_out_valid         <= 1'b0;
      stream_out_channel       <= 1'b0;
    end else if (transfer) begin
      if (fwd) begin
        stream_out_data          <= fwd_ch ? stream_in1_data : stream_in0_data;
        stream_out_startofpacket <= fwd_ch ? stream_in1_startofpacket : stream_in0_startofpacket;
        stream_out_endofpacket   <= fwd_eop;
        stream_out_empty         <= fwd_ch ? stream_in1_empty : stream_in0_empty;
        stream_out_valid         <= 1'b1;
        stream_out_channel       <= fwd_ch;
      end else begin
        stream_out_valid <= 1'b0;
      end
    end
  end

  // Completed-packet and discarded-beat statistics.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_count0 <= 16'd0;
      pkt_count1 <= 16'd0;
      drop_count <= 8'd0;
    end else begin
      if (fwd && fwd_eop && !fwd_ch) pkt_count0 <= pkt_count0 + 16'd1;
      if (fwd && fwd_eop && fwd_ch)  pkt_count1 <= pkt_count1 + 16'd1;
      drop_count <= sat_add8(drop_count, drop_inc);
    end
  end

endmodule

// File: tb/tb_video_csc_stream_arbiter.sv
// Directed bench for the two-source packet arbiter.
module tb_video_csc_stream_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] d0, d1;
  logic        s0, e0, v0, s1, e1, v1;
  logic [1:0]  m0, m1;
  logic        r0, r1;
  logic [1:0]  port_enable;
  logic        so_rdy;
  logic [23:0] so_d;
  logic        so_s, so_e, so_v, so_ch;
  logic [1:0]  so_m;
  logic [15:0] pc0, pc1;
  logic [7:0]  dc;
  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  video_csc_stream_arbiter #(.DW(23), .EW(1)) dut (
    .clk(clk), .reset(reset),
    .stream_in0_data(d0), .stream_in0_startofpacket(s0), .stream_in0_endofpacket(e0),
    .stream_in0_empty(m0), .stream_in0_valid(v0), .stream_in0_ready(r0),
    .stream_in1_data(d1), .stream_in1_startofpacket(s1), .stream_in1_endofpacket(e1),
    .stream_in1_empty(m1), .stream_in1_valid(v1), .stream_in1_ready(r1),
    .port_enable(port_enable), .stream_out_ready(so_rdy),
    .stream_out_data(so_d), .stream_out_startofpacket(so_s), .stream_out_endofpacket(so_e),
    .stream_out_empty(so_m), .stream_out_valid(so_v), .stream_out_channel(so_ch),
    .pkt_count0(pc0), .pkt_count1(pc1), .drop_count(dc)
  );

  task automatic drv0(input logic v, input logic s, input logic e, input logic [23:0] d);
    v0 = v; s0 = s; e0 = e; d0 = d; m0 = d[1:0];
  endtask

  task automatic drv1(input logic v, input logic s, input logic e, input logic [23:0] d);
    v1 = v; s1 = s; e1 = e; d1 = d; m1 = d[1:0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; port_enable = 2'b11; so_rdy = 1'b1;
    drv0(1, 1, 0, 24'h111111); drv1(1, 1, 0, 24'h222222);
    #2;
    total++; if (r0 !== 1'b0 || r1 !== 1'b0) $display("FAIL reset_ready got %b%b want 00", r0, r1); else passed++;
    tick();
    total++; if (so_v !== 1'b0 || so_d !== 24'h0 || so_ch !== 1'b0) $display("FAIL reset_out got v=%b d=%h ch=%b want 0", so_v, so_d, so_ch); else passed++;
    total++; if (pc0 !== 16'd0 || pc1 !== 16'd0 || dc !== 8'd0) $display("FAIL reset_counters got %0d %0d %0d want 0", pc0, pc1, dc); else passed++;
    total++; if (dut.prio !== 1'b0) $display("FAIL reset_prio got %b want 0", dut.prio); else passed++;
    drv0(0, 0, 0, 24'h0); drv1(0, 0, 0, 24'h0);
    reset = 1'b1;
  endtask

  task automatic test_single();
    drv1(1, 1, 1, 24'hABCDE1);
    #1;
    total++; if (r1 !== 1'b1 || r0 !== 1'b0) $display("FAIL single_ready got %b%b want 10", r1, r0); else passed++;
    tick();
    drv1(0, 0, 0, 24'h0);
    total++; if (so_v !== 1'b1 || so_d !== 24'hABCDE1 || so_ch !== 1'b1) $display("FAIL single_out got v=%b d=%h ch=%b want 1 abcde1 1", so_v, so_d, so_ch); else passed++;
    total++; if (so_s !== 1'b1 || so_e !== 1'b1 || so_m !== 2'b01) $display("FAIL single_flags got s=%b e=%b m=%b want 1 1 01", so_s, so_e, so_m); else passed++;
    total++; if (pc1 !== 16'd1 || pc0 !== 16'd0) $display("FAIL single_count got %0d %0d want 1 0", pc1, pc0); else passed++;
    total++; if (int'(dut.state) !== 0 || dut.prio !== 1'b0) $display("FAIL single_fsm got st=%0d prio=%b want 0 0", dut.state, dut.prio); else passed++;
    tick();
    total++; if (so_v !== 1'b0) $display("FAIL single_bubble got %b want 0", so_v); else passed++;
  endtask

  task automatic test_tie();
    for (int i = 0; i < 4; i++) begin
      drv0(1, i == 0, i == 3, 24'h000100 + 24'(i));
      drv1(1, 1, 0, 24'h000200);
      #1;
      total++; if (r0 !== 1'b1 || r1 !== 1'b0) $display("FAIL tie_ready0 beat %0d got %b%b want 10", i, r0, r1); else passed++;
      tick();
      total++; if (so_v !== 1'b1 || so_ch !== 1'b0 || so_d !== 24'h000100 + 24'(i)) $display("FAIL tie_out0 beat %0d got v=%b ch=%b d=%h", i, so_v, so_ch, so_d); else passed++;
      total++; if (so_s !== (i == 0) || so_e !== (i == 3)) $display("FAIL tie_flags0 beat %0d got s=%b e=%b", i, so_s, so_e); else passed++;
    end
    total++; if (dut.prio !== 1'b1) $display("FAIL tie_prio_mid got %b want 1", dut.prio); else passed++;
    drv0(0, 0, 0, 24'h0);
    for (int i = 0; i < 2; i++) begin
      drv1(1, i == 0, i == 1, 24'h000200 + 24'(i));
      #1;
      total++; if (r1 !== 1'b1 || r0 !== 1'b0) $display("FAIL tie_ready1 beat %0d got %b%b want 10", i, r1, r0); else passed++;
      tick();
      total++; if (so_v !== 1'b1 || so_ch !== 1'b1 || so_d !== 24'h000200 + 24'(i)) $display("FAIL tie_out1 beat %0d got v=%b ch=%b d=%h", i, so_v, so_ch, so_d); else passed++;
    end
    drv1(0, 0, 0, 24'h0);
    total++; if (dut.prio !== 1'b0) $display("FAIL tie_prio_end got %b want 0", dut.prio); else passed++;
    total++; if (pc0 !== 16'd1 || pc1 !== 16'd2) $display("FAIL tie_counts got %0d %0d want 1 2", pc0, pc1); else passed++;
  endtask

  task automatic test_stall();
    drv0(1, 1, 0, 24'h000300);
    tick();
    total++; if (so_d !== 24'h000300 || int'(dut.state) !== 1) $display("FAIL stall_first got d=%h st=%0d want 300 1", so_d, dut.state); else passed++;
    so_rdy = 1'b0;
    drv0(1, 0, 0, 24'h000301); drv1(1, 0, 0, 24'h0000EE);
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (r0 !== 1'b0 || r1 !== 1'b0) $display("FAIL stall_ready cyc %0d got %b%b want 00", i, r0, r1); else passed++;
      tick();
      total++; if (so_v !== 1'b1 || so_d !== 24'h000300 || so_s !== 1'b1) $display("FAIL stall_hold cyc %0d got v=%b d=%h", i, so_v, so_d); else passed++;
    end
    total++; if (dc !== 8'd0) $display("FAIL stall_nodrop got %0d want 0", dc); else passed++;
    so_rdy = 1'b1;
    drv1(0, 0, 0, 24'h0);
    tick();
    total++; if (so_d !== 24'h000301 || so_s !== 1'b0) $display("FAIL stall_resume got d=%h want 301", so_d); else passed++;
    drv0(1, 0, 1, 24'h000302);
    tick();
    drv0(0, 0, 0, 24'h0);
    total++; if (so_d !== 24'h000302 || so_e !== 1'b1 || pc0 !== 16'd2) $display("FAIL stall_end got d=%h e=%b pc0=%0d", so_d, so_e, pc0); else passed++;
    total++; if (int'(dut.state) !== 0 || dut.prio !== 1'b1) $display("FAIL stall_fsm got st=%0d prio=%b want 0 1", dut.state, dut.prio); else passed++;
  endtask

  task automatic test_drop();
    for (int i = 0; i < 3; i++) begin
      drv0(1, 0, 0, 24'h000400 + 24'(i));
      #1;
      total++; if (r0 !== 1'b1) $display("FAIL drop_ready beat %0d got %b want 1", i, r0); else passed++;
      tick();
      total++; if (so_v !== 1'b0) $display("FAIL drop_novalid beat %0d got %b want 0", i, so_v); else passed++;
    end
    total++; if (dc !== 8'd3) $display("FAIL drop_three got %0d want 3", dc); else passed++;
    for (int i = 0; i < 297; i++) tick();
    drv0(0, 0, 0, 24'h0);
    total++; if (dc !== 8'd255) $display("FAIL drop_saturate got %0d want 255", dc); else passed++;
    total++; if (pc0 !== 16'd2 || so_v !== 1'b0) $display("FAIL drop_side got pc0=%0d v=%b", pc0, so_v); else passed++;
  endtask

  task automatic test_enable();
    port_enable = 2'b01;
    drv0(1, 1, 0, 24'h000500); drv1(1, 1, 0, 24'h000600);
    #1;
    total++; if (r0 !== 1'b1 || r1 !== 1'b0) $display("FAIL enable_grant got %b%b want 10", r0, r1); else passed++;
    tick();
    port_enable = 2'b00;
    for (int i = 1; i < 3; i++) begin
      drv0(1, 0, i == 2, 24'h000500 + 24'(i));
      #1;
      total++; if (r0 !== 1'b1 || r1 !== 1'b0) $display("FAIL enable_keep beat %0d got %b%b want 10", i, r0, r1); else passed++;
      tick();
      total++; if (so_ch !== 1'b0 || so_d !== 24'h000500 + 24'(i)) $display("FAIL enable_out beat %0d got ch=%b d=%h", i, so_ch, so_d); else passed++;
    end
    drv0(0, 0, 0, 24'h0);
    #1;
    total++; if (r1 !== 1'b0) $display("FAIL enable_masked got %b want 0", r1); else passed++;
    total++; if (pc0 !== 16'd3 || so_e !== 1'b1) $display("FAIL enable_done got pc0=%0d e=%b want 3 1", pc0, so_e); else passed++;
    drv1(0, 0, 0, 24'h0);
    tick();
    port_enable = 2'b11;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      drv1(1, i == 0, 0, 24'h000700 + 24'(i));
      tick();
    end
    total++; if (int'(dut.state) !== 2 || so_d !== 24'h000701) $display("FAIL rmid_pre got st=%0d d=%h want 2 701", dut.state, so_d); else passed++;
    drv1(1, 0, 0, 24'h000702);
    reset = 1'b0;
    #1;
    total++; if (so_v !== 1'b0 || so_d !== 24'h0 || so_ch !== 1'b0 || so_s !== 1'b0) $display("FAIL rmid_out got v=%b d=%h ch=%b", so_v, so_d, so_ch); else passed++;
    total++; if (r0 !== 1'b0 || r1 !== 1'b0 || dc !== 8'd0 || pc0 !== 16'd0) $display("FAIL rmid_state got r=%b%b dc=%0d pc0=%0d", r0, r1, dc, pc0); else passed++;
    #2;
    reset = 1'b1;
    for (int i = 2; i < 5; i++) begin
      drv1(1, 0, i == 4, 24'h000700 + 24'(i));
      #1;
      total++; if (r1 !== 1'b1) $display("FAIL rmid_ready beat %0d got %b want 1", i, r1); else passed++;
      tick();
      total++; if (so_v !== 1'b0) $display("FAIL rmid_novalid beat %0d got %b want 0", i, so_v); else passed++;
    end
    drv1(0, 0, 0, 24'h0);
    total++; if (dc !== 8'd3 || pc1 !== 16'd0) $display("FAIL rmid_drop got dc=%0d pc1=%0d want 3 0", dc, pc1); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_stall();
    test_drop();
    test_enable();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/video_csc_stream_arbiter.md
VIDEO_CSC_STREAM_ARBITER -- requirements
Module: video_csc_stream_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default 23, meaning the MSB index of the data bus (24-bit YCrCb beats).
REQ-002 The block SHALL have parameter EW, default 1, meaning the MSB index of the empty bus.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have ports stream_in0_data/startofpacket/endofpacket/empty/valid, inputs, DW+1/1/1/EW+1/1 bits: source 0 Avalon-ST sink.
REQ-006 The block SHALL have port stream_in0_ready, output, 1 bit: source 0 backpressure.
REQ-007 The block SHALL have ports stream_in1_data/startofpacket/endofpacket/empty/valid/ready, identical to port 0, for source 1.
REQ-008 The block SHALL have port port_enable, input, 2 bits: bit n enables arbitration for source n.
REQ-009 The block SHALL have port stream_out_ready, input, 1 bit: downstream (CSC) backpressure.
REQ-010 The block SHALL have ports stream_out_data/startofpacket/endofpacket/empty/valid, registered outputs, DW+1/1/1/EW+1/1 bits: merged stream to the CSC.
REQ-011 The block SHALL have port stream_out_channel, registered output, 1 bit: source index of the current output beat.
REQ-012 The block SHALL have ports pkt_count0 and pkt_count1, outputs, 16 bits each: completed packets per source.
REQ-013 The block SHALL have port drop_count, output, 8 bits: stray beats discarded.

Function
REQ-014 transfer SHALL equal ~stream_out_valid | stream_out_ready; a beat is accepted from source n when stream_inN_valid & stream_inN_ready.
REQ-015 State machine SHALL have states IDLE, GRANT0 and GRANT1, plus a 1-bit priority pointer prio (the source favoured on a tie).
REQ-016 In IDLE, the candidate SHALL be any source n with port_enable[n] & valid & startofpacket; if both are candidates, prio wins.
REQ-017 In IDLE, the winner's ready SHALL equal transfer and the loser's ready SHALL be 0; acceptance happens in the same cycle (no grant bubble).
REQ-018 In IDLE, an accepted winning beat without endofpacket SHALL move the FSM to GRANTn.
REQ-019 In IDLE, an accepted winning beat with startofpacket & endofpacket SHALL leave the FSM in IDLE and set prio to the other source.
REQ-020 In IDLE, a valid beat without startofpacket (stray) from any source SHALL get ready=1 when that source is not the winner, be discarded, and increment drop_count (saturating at 255, counting each discarded beat once).
REQ-021 In GRANTn, ready for source n SHALL equal transfer and ready for the other source SHALL be 0; the other source's stray beats are not dropped.
REQ-022 In GRANTn, an accepted beat with endofpacket SHALL return the FSM to IDLE and set prio to ~n.
REQ-023 In GRANTn, a startofpacket beat mid-packet SHALL be forwarded unchanged with no state change.
REQ-024 Clearing port_enable[n] during GRANTn SHALL NOT abort the packet; it takes effect only at the next arbitration in IDLE.
REQ-025 When transfer=1 and a beat is accepted, the output registers SHALL load that beat, set stream_out_valid=1, and set stream_out_channel=n on the next edge (latency exactly 1 cycle).
REQ-026 When transfer=1 and no beat is accepted, stream_out_valid SHALL go to 0 and the other output fields SHALL hold their values.
REQ-027 When transfer=0, all output registers SHALL hold.
REQ-028 pkt_countn SHALL increment (wrapping from 65535 to 0) on each accepted endofpacket beat from source n that is forwarded, not dropped.
REQ-029 An endofpacket beat and a winning startofpacket beat from different sources SHALL never both be accepted in the same cycle.

Reset
REQ-030 On reset low, asynchronously: FSM=IDLE, prio=0, stream_out_* =0, stream_out_channel=0, all counters=0, both readys=0.
REQ-031 Reset asserted mid-packet SHALL abandon the packet with no eop emitted; after release, the remaining beats are treated as stray.

Verification
REQ-032 Verification SHALL cover: both sources present sop at once, prio=0 -> source 0 packet of 4 beats, then source 1 packet; channel 0,0,0,0,1…; prio ends at 0.
REQ-033 Verification SHALL cover: a single-beat packet (sop&eop) on source 1 with source 0 idle -> output 1 cycle later, pkt_count1=1, FSM stays IDLE, prio=0.
REQ-034 Verification SHALL cover: stream_out_ready=0 for 5 cycles during GRANT0 -> output held stable, both readys=0, no beats lost or duplicated.
REQ-035 Verification SHALL cover: 3 non-sop beats on source 0 in IDLE -> drop_count=3, no output valid; 300 stray beats -> drop_count=255.
REQ-036 Verification SHALL cover: port_enable=2'b01 with both sources at sop -> only source 0 granted; clearing bit 0 mid-packet -> packet completes.
REQ-037 Verification SHALL cover: reset pulsed in GRANT1 after 2 of 5 beats -> all outputs 0 immediately; remaining 3 beats dropped, drop_count=3.
